// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, sequencer state type and decode helpers shared by the
// multiply/divide unit, the decoder and the stall unit.
package mdu_pkg;

   localparam logic [3:0] MDOP_NONE  = 4'd0;
   localparam logic [3:0] MDOP_MULT  = 4'd1;
   localparam logic [3:0] MDOP_MULTU = 4'd2;
   localparam logic [3:0] MDOP_DIV   = 4'd3;
   localparam logic [3:0] MDOP_DIVU  = 4'd4;
   localparam logic [3:0] MDOP_MFHI  = 4'd5;
   localparam logic [3:0] MDOP_MFLO  = 4'd6;
   localparam logic [3:0] MDOP_MTHI  = 4'd7;
   localparam logic [3:0] MDOP_MTLO  = 4'd8;

   typedef enum logic {ST_IDLE, ST_RUN} mdu_state_e;

   function automatic logic is_md_start(input logic [3:0] op);
      return op >= MDOP_MULT && op <= MDOP_DIVU;
   endfunction

   function automatic logic is_md(input logic [3:0] op);
      return op >= MDOP_MULT && op <= MDOP_MTLO;
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 32x32 multiply/divide producing the {hi,lo} result
// and a divide-by-zero flag.
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div0
);

   logic [63:0] sprod, uprod;
   logic [31:0] bd, abs_a, abs_b, sq, sr, uq, ur, q, r;

   always_comb begin
      sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      uprod = {32'd0, a} * {32'd0, b};
      // a zero divisor is replaced so the dividers never see 0; the result is discarded anyway
      bd = (b == 32'd0) ? 32'd1 : b;
      abs_a = a[31] ? -a : a;
      abs_b = bd[31] ? -bd : bd;
      sq = abs_a / abs_b;
      sr = abs_a % abs_b;
      uq = a / bd;
      ur = a % bd;
      q = (a[31] ^ bd[31]) ? -sq : sq;
      r = a[31] ? -sr : sr;
      div0 = (op == MDOP_DIV || op == MDOP_DIVU) && b == 32'd0;
      {hi, lo} = op == MDOP_MULT  ? sprod :
                 op == MDOP_MULTU ? uprod :
                 op == MDOP_DIV   ? {r, q} :
                 op == MDOP_DIVU  ? {ur, uq} : 64'd0;
   end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: multiply/divide sequencer owning HI/LO, modelling fixed latency
// with a countdown and driving Start/Busy for the stall unit.
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:0]  MDop_E,
   input  logic [31:0] A_E,
   input  logic [31:0] B_E,
   output logic        Start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDout_E
);

   localparam int MAX_CYCLES = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);

   mdu_state_e  state;
   logic [CW-1:0] cnt;
   logic [31:0] res_hi, res_lo, a_hi, a_lo;
   logic        res_ok, div0;

   mdu_arith u_arith (
      .op   (MDop_E),
      .a    (A_E),
      .b    (B_E),
      .hi   (a_hi),
      .lo   (a_lo),
      .div0 (div0)
   );

   assign Busy    = state == ST_RUN;
   assign Start   = is_md_start(MDop_E) && !Busy;
   assign MDout_E = MDop_E == MDOP_MFHI ? HI : MDop_E == MDOP_MFLO ? LO : 32'd0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         res_hi <= '0;
         res_lo <= '0;
         res_ok <= 1'b0;
         HI     <= '0;
         LO     <= '0;
      end else if (state == ST_IDLE) begin
         if (Start) begin
            state  <= ST_RUN;
            cnt    <= MDop_E <= MDOP_MULTU ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
            res_hi <= a_hi;
            res_lo <= a_lo;
            res_ok <= !div0;
         end else if (MDop_E == MDOP_MTHI) begin
            HI <= A_E;
         end else if (MDop_E == MDOP_MTLO) begin
            LO <= A_E;
         end
      end else if (cnt == CW'(1)) begin
         // last busy cycle: commit unless the divisor was zero
         state <= ST_IDLE;
         cnt   <= '0;
         if (res_ok) begin
            HI <= res_hi;
            LO <= res_lo;
         end
      end else begin
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed test-plan sequences plus random ops, checked every cycle
// against a behavioural HI/LO model.
module tb_mdu_seq;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  op = 4'd0;
   logic [31:0] a = 32'd0, b = 32'd0;
   logic        Start, Busy;
   logic [31:0] HI, LO, MDout_E;

   mdu_seq #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .MDop_E  (op),
      .A_E     (a),
      .B_E     (b),
      .Start   (Start),
      .Busy    (Busy),
      .HI      (HI),
      .LO      (LO),
      .MDout_E (MDout_E)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   bit chk = 0;
   logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
   logic        p_ok = 0;
   int          rem = 0;

   function automatic logic [63:0] ref_res(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx = longint'($signed(x));
      longint sy = longint'($signed(y));
      longint unsigned ux = 64'(x);
      longint unsigned uy = 64'(y);
      if (o == MDOP_MULT) return 64'(sx * sy);
      if (o == MDOP_MULTU) return ux * uy;
      if (y == 0) return 64'd0;
      if (o == MDOP_DIV) return {32'(sx % sy), 32'(sx / sy)};
      if (o == MDOP_DIVU) return {32'(ux % uy), 32'(ux / uy)};
      return 64'd0;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_ok = 0; rem = 0;
   endtask

   always @(negedge clk) begin
      if (chk) begin
         check("busy", 64'(Busy), 64'(rem > 0));
         check("start", 64'(Start), 64'(op >= 1 && op <= 4 && rem == 0));
         check("hi", 64'(HI), 64'(m_hi));
         check("lo", 64'(LO), 64'(m_lo));
         check("mdout", 64'(MDout_E), op == MDOP_MFHI ? 64'(m_hi) : op == MDOP_MFLO ? 64'(m_lo) : 64'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      if (reset_n) begin
         if (rem > 0) begin
            rem--;
            if (rem == 0 && p_ok) begin m_hi = p_hi; m_lo = p_lo; end
         end else if (op >= 1 && op <= 4) begin
            rem = op <= MDOP_MULTU ? 5 : 10;
            p_ok = !(op >= MDOP_DIV && b == 0);
            {p_hi, p_lo} = ref_res(op, a, b);
         end else if (op == MDOP_MTHI) m_hi = a;
         else if (op == MDOP_MTLO) m_lo = a;
      end
      #1;
   endtask

   task automatic drive(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      op = o; a = x; b = y;
      tick();
   endtask

   task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int n);
      drive(o, x, y);
      repeat (n) drive(MDOP_NONE, 0, 0);
   endtask

   initial begin
      reset_n = 1'b0;
      check("ref_mult", ref_res(MDOP_MULT, 32'hFFFFFFFF, 32'd2), 64'hFFFFFFFF_FFFFFFFE);
      check("ref_div_ovf", ref_res(MDOP_DIV, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
      check("ref_div_neg", ref_res(MDOP_DIV, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
      tick(); tick();
      reset_n = 1'b1;
      check("rst_hi", 64'(HI), 64'd0);
      check("rst_busy", 64'(Busy), 64'd0);
      chk = 1;

      run_op(MDOP_MULT, 32'hFFFFFFFF, 32'd2, 5);
      check("mult", {HI, LO}, 64'hFFFFFFFF_FFFFFFFE);
      check("mult_busy", 64'(Busy), 64'd0);
      run_op(MDOP_MULTU, 32'hFFFFFFFF, 32'd2, 5);
      check("multu", {HI, LO}, 64'h00000001_FFFFFFFE);
      run_op(MDOP_DIV, 32'hFFFFFFF9, 32'd2, 10);
      check("div", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
      run_op(MDOP_DIVU, 32'd7, 32'd2, 10);
      check("divu", {HI, LO}, 64'h00000001_00000003);
      run_op(MDOP_DIV, 32'h80000000, 32'hFFFFFFFF, 10);
      check("div_ovf", {HI, LO}, 64'h00000000_80000000);
      drive(MDOP_MTHI, 32'h1234, 0);
      drive(MDOP_MTLO, 32'h5678, 0);
      run_op(MDOP_DIV, 32'd5, 32'd0, 10);
      check("div0", {HI, LO}, 64'h00001234_00005678);

      drive(MDOP_MTLO, 32'hAA, 0);
      op = MDOP_MFLO;
      #1 check("mflo", 64'(MDout_E), 64'hAA);
      tick();

      drive(MDOP_MULT, 32'd3, 32'd4);
      drive(MDOP_MTHI, 32'h99, 0);
      drive(MDOP_MULT, 32'd5, 32'd6);
      drive(MDOP_MFHI, 0, 0);
      check("busy_ign", {HI, LO}, 64'h00001234_000000AA);
      repeat (2) drive(MDOP_NONE, 0, 0);
      check("busy_commit", {HI, LO}, 64'h00000000_0000000C);

      drive(MDOP_MTHI, 32'h55, 0);
      drive(MDOP_DIV, 32'd100, 32'd7);
      repeat (2) drive(MDOP_NONE, 0, 0);
      #2 reset_n = 1'b0;
      model_reset();
      #1 check("abort", {HI, LO}, 64'd0);
      check("abort_busy", 64'(Busy), 64'd0);
      tick();
      reset_n = 1'b1;
      run_op(MDOP_MULT, 32'd6, 32'd7, 5);
      check("post_rst", {HI, LO}, 64'h00000000_0000002A);

      for (int i = 0; i < 400; i++) begin
         logic [3:0]  o;
         logic [31:0] x, y;
         o = 4'($urandom_range(0, 15));
         x = $urandom;
         y = $urandom;
         if ($urandom_range(0, 7) == 0) y = 0;
         if ($urandom_range(0, 15) == 0) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
         if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 9));
         drive(o, x, y);
      end
      repeat (12) drive(MDOP_NONE, 0, 0);
      chk = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Multiply/divide unit sequencer for the five-stage MIPS pipeline, sitting in the E stage beside the ALU. It accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO operations and owns the HI/LO registers. It models fixed multi-cycle latency with a countdown, and drives the `Start` and `Busy` signals that the stall/forward unit uses to hold HI/LO-touching instructions in D.

## Interface
- `MUL_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.
- `clk  in  1`: pipeline clock.
- `reset_n  in  1`: asynchronous, active-low reset.
- `MDop_E  in  4`: operation code of the E-stage instruction; encoding is in the shared package.
- `A_E  in  32`: forwarded rs value.
- `B_E  in  32`: forwarded rt value.
- `Start  out  1`: combinational; high when `MDop_E` is MULT/MULTU/DIV/DIVU and `Busy` is low.
- `Busy  out  1`: registered; high while an operation is in flight.
- `HI  out  32`: architectural HI register.
- `LO  out  32`: architectural LO register.
- `MDout_E  out  32`: combinational; HI for MFHI, LO for MFLO, 0 otherwise.

## Operation
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8. Codes 9–15 are treated as NONE.
- States:
  - IDLE: `Busy`=0, counter=0.
  - RUN: `Busy`=1, counter counts down.
- IDLE → RUN on `Start`.
  - Load counter with `MUL_CYCLES` or `DIV_CYCLES` (MULT/MULTU vs DIV/DIVU).
  - Latch the 64-bit result into internal `res_hi`/`res_lo` at the same edge.
- RUN: decrement the counter each cycle. When the counter is 1, at that edge:
  - Commit `res_hi`/`res_lo` to HI/LO.
  - Clear `Busy`; go to IDLE.
- Arithmetic:
  - MULT: signed 32×32 → 64; {HI,LO} = product.
  - MULTU: unsigned 32×32 → 64; {HI,LO} = product.
  - DIV: signed, quotient truncates toward zero; LO = quotient, HI = remainder (sign of dividend).
  - 0x80000000 / 0xFFFFFFFF (signed DIV) → LO=0x80000000, HI=0.
  - DIVU: unsigned; LO = quotient, HI = remainder.
- Divide by zero (B_E=0): the operation still occupies `DIV_CYCLES`, but HI/LO keep their prior values (no commit).
- MTHI/MTLO: write `A_E` to HI/LO at the next edge, only in IDLE.
- Illegal-while-busy inputs are ignored: start ops, MT*, and MF* in RUN. The stall unit guarantees they do not reach E during RUN; here they must not change state.
- MF* in IDLE reads the current HI/LO, so an MT* in the previous cycle is visible.

## Timing
- Reset (async, `reset_n`=0):
  - HI=0, LO=0, `Busy`=0, counter=0, state IDLE, `res_hi`=`res_lo`=0.
  - `Start` and `MDout_E` follow their combinational definitions.
- Reset mid-operation aborts: HI/LO return to 0 and no commit occurs.
- Start in cycle t:
  - `Busy`=1 for cycles t+1 … t+N (N = `MUL_CYCLES` or `DIV_CYCLES`).
  - HI/LO hold the new value from cycle t+N+1.
  - `Busy`=0 in cycle t+N+1.
- Back-to-back: a new start is accepted in cycle t+N+1 (IDLE), so an op can issue again immediately after completion.
- The stall unit uses `Start || Busy`; `Start` must never assert while `Busy`=1.
- MT* in cycle t → HI/LO updated at the end of t → MF* in t+1 reads the new value.
- Counter width: $clog2(max(MUL_CYCLES, DIV_CYCLES)+1) bits; both parameters ≥ 1.

## Structure
- Shared package `mdu_pkg`: op code localparams (MDOP_NONE … MDOP_MTLO) and helpers `is_md_start(op)` and `is_md(op)`. The decoder and stall unit also use these helpers.
- Sub-module `mdu_arith`: purely combinational. Inputs: op, A, B. Outputs: 64-bit {hi,lo} result and `div0` flag.
- `mdu_seq` holds the FSM, counter, result latch and HI/LO.

## Test plan
- Reset, then MULT with A=0xFFFFFFFF, B=2:
  - `Start`=1 in cycle 0.
  - `Busy`=1 in cycles 1–5.
  - Cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFE, `Busy`=0.
  - MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=-7 (0xFFFFFFF9), B=2:
  - `Busy` for 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/2 → LO=3, HI=1.
- Edge divides:
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIV by 0 after MTHI 0x1234 / MTLO 0x5678 → `Busy` for 10 cycles, then HI=0x1234, LO=0x5678 unchanged.
- MTLO 0xAA in cycle t, MFLO in t+1 → `MDout_E`=0xAA.
- MULT issued, then MTHI/MULT/MFHI driven while `Busy` → ignored: `Start`=0, HI/LO unchanged until the original commit.
- Assert `reset_n`=0 in cycle 3 of a DIV → HI=LO=0 and `Busy`=0 immediately. After release, a new MULT issues normally.
